// File: rtl/cpu_clock_control.sv
// CPU clock-enable generator: run / single-step / halt control.
// Optional cycle counter enabled by defining CPU_CYCLE_COUNT_EN.
module cpu_clock_control #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic             running,
`ifdef CPU_CYCLE_COUNT_EN
  output logic [CNT_W-1:0] cycle_count,
`endif
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);

  logic slow_m, slow_clk_s, slow_clk_prev;
  logic run_m, run_sw_s;
  logic btn_m, step_btn_s;
  logic halt_m, halt_s;
  logic tick;

  logic          db_level, db_prev;
  logic [DW-1:0] db_cnt;
  logic          press;

  state_t state_q, state_d;
  logic   en_d;

  // two-flop synchronizers for all raw inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slow_m     <= 1'b0;
      slow_clk_s <= 1'b0;
      run_m      <= 1'b0;
      run_sw_s   <= 1'b0;
      btn_m      <= 1'b0;
      step_btn_s <= 1'b0;
      halt_m     <= 1'b0;
      halt_s     <= 1'b0;
    end else begin
      slow_m     <= slow_clk;
      slow_clk_s <= slow_m;
      run_m      <= run_sw;
      run_sw_s   <= run_m;
      btn_m      <= step_btn;
      step_btn_s <= btn_m;
      halt_m     <= halt;
      halt_s     <= halt_m;
    end
  end

  // registered rising-edge detect on the synchronized slow clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slow_clk_prev <= 1'b0;
      tick          <= 1'b0;
    end else begin
      slow_clk_prev <= slow_clk_s;
      tick          <= slow_clk_s & ~slow_clk_prev;
    end
  end

  // debounce: accept a new level after a stable run of differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      db_prev <= db_level;
      if (step_btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= step_btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign press = db_level & ~db_prev;

  // state, enable pulse and running flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HALT;
      cpu_en  <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      cpu_en  <= en_d;
      running <= (state_d == RUN);
    end
  end

  // next-state and pulse decision; exits win over tick
  always_comb begin
    state_d = HALT;
    en_d    = 1'b0;
    case (state_q)
      HALT: begin
        if (halt_s)
          state_d = HALT;
        else if (run_sw_s)
          state_d = RUN;
        else if (press)
          state_d = STEP;
        else
          state_d = HALT;
      end
      RUN: begin
        if (halt_s || !run_sw_s) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
          en_d    = tick;
        end
      end
      STEP: begin
        if (halt_s) begin
          state_d = HALT;
        end else if (run_sw_s) begin
          state_d = RUN;
        end else if (tick) begin
          state_d = HALT;
          en_d    = 1'b1;
        end else begin
          state_d = STEP;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  assign state = state_q;

`ifdef CPU_CYCLE_COUNT_EN
  // count issued enable pulses, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycle_count <= '0;
    else if (cpu_en)
      cycle_count <= cycle_count + CNT_W'(1);
  end
`endif

endmodule
